seg595_scan_driver: RTL and testbench
=====================================

SEG595_SCAN_DRIVER -- requirements
Module: seg595_scan_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of digits scanned (legal range 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 4, sclk half-period in clk cycles (legal range >= 1).
REQ-003 SHALL have parameter LATCH_CYCLES, default 3, slatch high time in clk cycles (legal range >= 1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 1000, idle time after each latch in clk cycles (legal range >= 0).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port data  input  8*N_DIGITS  digit bytes; digit 0 = data[8*N_DIGITS-1 -: 8] (leftmost).
REQ-008 SHALL have port load  input  1  capture request, honoured only while ready=1.
REQ-009 SHALL have port raw_mode  input  1  sampled with load: 1 = bytes are active-low segment codes, 0 = ASCII to decode.
REQ-010 SHALL have port blank  input  1  level; 1 forces every shifted segment byte to 8'hFF.
REQ-011 SHALL have port ready  output  1  high when the pending buffer is empty.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-013 SHALL have port sda, sclk, slatch  output  1 each  595 serial data, shift clock, storage latch.

Function
REQ-014 SHALL hold two buffers: pending (data + raw flag, plus a valid bit) and active (used for scanning).
REQ-015 SHALL capture data and raw_mode into pending, and set pending valid, on a cycle with load=1 and ready=1; ready SHALL be 0 from the next cycle.
REQ-016 SHALL ignore load while ready=0; pending SHALL NOT be overwritten.
REQ-017 SHALL copy pending into active and clear valid only in the LOAD_DIGIT cycle of digit 0; ready SHALL return to 1 on the next cycle, so a whole frame never mixes old and new data.
REQ-018 SHALL scan continuously from reset release with FSM states LOAD_DIGIT -> SHIFT -> LATCH -> HOLD -> LOAD_DIGIT (next digit index, wrapping from N_DIGITS-1 to 0).
REQ-019 LOAD_DIGIT SHALL last 1 cycle and form the 16-bit word {pos, seg}: pos = one-hot with bit i set for digit i; seg = decoded or raw byte, or 8'hFF if blank=1.
REQ-020 SHALL decode (active-low .GFEDCBA) with this table: '0' C0, '1' F9, '2' A4, '3' B0, '4' 99, '5' 92, '6' 82, '7' F8, '8' 80, '9' 90, 'A'/'a' 88, 'B'/'b' 83, 'C'/'c' C6, 'D'/'d' A1, 'E'/'e' 86, 'F'/'f' 8E, '-' BF, '.' 7F; any other value SHALL decode to FF.
REQ-021 SHIFT SHALL last exactly 32*CLK_DIV cycles and send 16 bits MSB first: per bit, sclk low for CLK_DIV cycles then high for CLK_DIV cycles; sda SHALL change only while sclk is low and be stable when sclk rises.
REQ-022 LATCH SHALL last LATCH_CYCLES cycles with slatch=1, sclk=0 and sda=0; slatch SHALL be 0 in all other states.
REQ-023 HOLD SHALL last HOLD_CYCLES cycles with all serial outputs 0; if HOLD_CYCLES=0, HOLD SHALL be skipped.
REQ-024 Digit period SHALL be 1 + 32*CLK_DIV + LATCH_CYCLES + HOLD_CYCLES cycles.
REQ-025 frame_done SHALL pulse during the final cycle of digit N_DIGITS-1, which is its last HOLD cycle, or its last LATCH cycle if HOLD_CYCLES=0.
REQ-026 A change of blank SHALL take effect at the next LOAD_DIGIT; a digit already in SHIFT SHALL finish unchanged.

Reset
REQ-027 While rst_n=0 at a clk edge: sda=0, sclk=0, slatch=0, frame_done=0, ready=1, pending valid=0.
REQ-028 Reset SHALL set active to all 8'hFF with raw flag=1, and set the FSM to LOAD_DIGIT for digit 0.
REQ-029 Reset asserted mid-SHIFT or mid-LATCH SHALL abort immediately; no partial latch pulse SHALL follow.

Verification (CLK_DIV=2, LATCH_CYCLES=3, HOLD_CYCLES=4, N_DIGITS=8; digit period 72)
REQ-030 Bench SHALL cover: reset release, no load -> eight 16-bit words 0x01FF, 0x02FF ... 0x80FF; frame_done every 576 cycles.
REQ-031 Bench SHALL cover: load "01234567" with raw_mode=0 -> ready drops next cycle and rises after the next digit-0 LOAD_DIGIT; that frame shifts 0x01C0, 0x02F9, 0x04A4 ... 0x80F8.
REQ-032 Bench SHALL cover: second load while ready=0 -> ignored; displayed frame is the first data only.
REQ-033 Bench SHALL cover: raw_mode=1, data all 8'h00, blank toggled to 1 during digit 3 SHIFT -> digit 3 shifts 0x0800, digits 4..7 shift 0x10FF ... 0x80FF.
REQ-034 Bench SHALL cover: rst_n low during digit 5 SHIFT -> sclk/sda/slatch 0 next cycle; after release, scan restarts at digit 0 with blank words 0x01FF.
REQ-035 Bench SHALL check: sda stable across every sclk rising edge; exactly 16 sclk rises per digit; slatch high exactly 3 cycles per digit.

Source files
------------

// File: rtl/seg595_scan_driver.sv
// Scans N_DIGITS seven-segment digits through a pair of 74HC595 shift registers.
// Each digit shifts a 16-bit word {one-hot position, active-low segments} MSB
// first, latches it, then holds for a fixed time before the next digit.
// Frame data is double-buffered: a load fills the pending buffer, and the
// pending buffer moves into the active buffer only at the start of a frame.
module seg595_scan_driver #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned LATCH_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic                  raw_mode,
  input  logic                  blank,
  output logic                  ready,
  output logic                  frame_done,
  output logic                  sda,
  output logic                  sclk,
  output logic                  slatch
);

  localparam int unsigned DATA_W  = 8 * N_DIGITS;
  localparam int unsigned DIG_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
  localparam int unsigned CNT_MAX = (LATCH_CYCLES > HOLD_CYCLES) ? LATCH_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PERIOD  = 1 + 32 * CLK_DIV + LATCH_CYCLES + HOLD_CYCLES;
  localparam int unsigned PER_W   = $clog2(PERIOD);

  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);
  localparam logic [PER_W-1:0] PER_FINAL  = PER_W'(PERIOD - 2);

  typedef enum logic [1:0] {
    S_LOAD_DIGIT,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t            state;
  logic [DIG_W-1:0]  digit;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        bit_idx;
  logic [CNT_W-1:0]  cnt;
  logic [PER_W-1:0]  per_cnt;
  logic [14:0]       shreg;

  logic [DATA_W-1:0] pend_data;
  logic              pend_raw;
  logic              pend_valid;
  logic [DATA_W-1:0] act_data;
  logic              act_raw;

  logic              use_pend;
  logic [DATA_W-1:0] src_data;
  logic              src_raw;
  logic [7:0]        cur_byte;
  logic [7:0]        seg;
  logic [7:0]        pos;
  logic [15:0]       word;
  logic [DIG_W-1:0]  next_digit;

  // ASCII to active-low .GFEDCBA segment code; unknown characters go dark
  function automatic logic [7:0] seg_decode(input logic [7:0] c);
    logic [7:0] s;
    case (c)
      8'h30:        s = 8'hC0;  // 0
      8'h31:        s = 8'hF9;  // 1
      8'h32:        s = 8'hA4;  // 2
      8'h33:        s = 8'hB0;  // 3
      8'h34:        s = 8'h99;  // 4
      8'h35:        s = 8'h92;  // 5
      8'h36:        s = 8'h82;  // 6
      8'h37:        s = 8'hF8;  // 7
      8'h38:        s = 8'h80;  // 8
      8'h39:        s = 8'h90;  // 9
      8'h41, 8'h61: s = 8'h88;  // A a
      8'h42, 8'h62: s = 8'h83;  // B b
      8'h43, 8'h63: s = 8'hC6;  // C c
      8'h44, 8'h64: s = 8'hA1;  // D d
      8'h45, 8'h65: s = 8'h86;  // E e
      8'h46, 8'h66: s = 8'h8E;  // F f
      8'h2D:        s = 8'hBF;  // -
      8'h2E:        s = 8'h7F;  // .
      default:      s = 8'hFF;
    endcase
    return s;
  endfunction

  // Digit 0 of a frame reads straight from pending when a swap is due,
  // so the whole frame shows the new data
  always_comb begin
    use_pend = (digit == '0) && pend_valid;
    src_data = use_pend ? pend_data : act_data;
    src_raw  = use_pend ? pend_raw : act_raw;
  end

  // Select the byte of the current digit (digit 0 is the leftmost byte)
  always_comb begin
    cur_byte = 8'hFF;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digit == DIG_W'(i)) begin
        cur_byte = src_data[8*(N_DIGITS-1-i) +: 8];
      end
    end
  end

  // Build the 16-bit word for the digit about to be shifted
  always_comb begin
    if (blank) begin
      seg = 8'hFF;
    end else if (src_raw) begin
      seg = cur_byte;
    end else begin
      seg = seg_decode(cur_byte);
    end
    pos        = 8'(8'd1 << digit);
    word       = {pos, seg};
    next_digit = (digit == LAST_DIGIT) ? '0 : digit + DIG_W'(1);
  end

  // Scan FSM, buffer management and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOAD_DIGIT;
      digit      <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      per_cnt    <= '0;
      shreg      <= '0;
      pend_data  <= '0;
      pend_raw   <= 1'b0;
      pend_valid <= 1'b0;
      act_data   <= '1;
      act_raw    <= 1'b1;
      ready      <= 1'b1;
      frame_done <= 1'b0;
      sda        <= 1'b0;
      sclk       <= 1'b0;
      slatch     <= 1'b0;
    end else begin
      // Period counter marks the final cycle of the last digit
      frame_done <= (digit == LAST_DIGIT) && (per_cnt == PER_FINAL);
      per_cnt    <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);

      if (load && ready) begin
        pend_data  <= data;
        pend_raw   <= raw_mode;
        pend_valid <= 1'b1;
        ready      <= 1'b0;
      end

      case (state)
        S_LOAD_DIGIT: begin
          if (use_pend) begin
            act_data   <= pend_data;
            act_raw    <= pend_raw;
            pend_valid <= 1'b0;
            ready      <= 1'b1;
          end
          shreg   <= word[14:0];
          sda     <= word[15];
          sclk    <= 1'b0;
          div_cnt <= '0;
          bit_idx <= '0;
          state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_idx == 4'd15) begin
              sclk   <= 1'b0;
              sda    <= 1'b0;
              slatch <= 1'b1;
              cnt    <= '0;
              state  <= S_LATCH;
            end else begin
              sclk    <= 1'b0;
              sda     <= shreg[14];
              shreg   <= {shreg[13:0], 1'b0};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            slatch <= 1'b0;
            cnt    <= '0;
            if (HOLD_CYCLES == 0) begin
              digit <= next_digit;
              state <= S_LOAD_DIGIT;
            end else begin
              state <= S_HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            digit <= next_digit;
            state <= S_LOAD_DIGIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_LOAD_DIGIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg595_scan_driver.sv
// Bench for seg595_scan_driver: decodes the serial stream back into latched
// words and compares them with a table-driven model of the display frame.
module tb_seg595_scan_driver;

  localparam int N     = 8;
  localparam int D     = 2;
  localparam int L     = 3;
  localparam int H     = 4;
  localparam int PER   = 1 + 32 * D + L + H;
  localparam int FRAME = N * PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [8*N-1:0] data = '0;
  logic          load = 1'b0;
  logic          raw_mode = 1'b0;
  logic          blank = 1'b0;
  logic          ready, frame_done, sda, sclk, slatch;

  seg595_scan_driver #(
    .N_DIGITS(N), .CLK_DIV(D), .LATCH_CYCLES(L), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .raw_mode(raw_mode),
    .blank(blank), .ready(ready), .frame_done(frame_done), .sda(sda),
    .sclk(sclk), .slatch(slatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  int t0 = 0;
  int fs = 0;

  logic [7:0] dec [256];
  logic [7:0] bytes_v [8];

  // Serial-stream observer state
  logic [15:0] words [$];
  int          lat_cyc [$];
  int          fd_cyc [$];
  int          unstable = 0, bad_rise = 0, bad_latch = 0, n_lat = 0;
  logic        p_sclk = 0, p_sda = 0, p_slatch = 0;
  logic [15:0] bits = '0;
  int          rises = 0, hi_cnt = 0;

  // Cycle count and the reset level seen by the DUT at each edge
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Reassemble latched words and watch serial timing
  always @(negedge clk) begin
    if (!rst_q) begin
      p_sclk = 0; p_sda = 0; p_slatch = 0; bits = '0; rises = 0; hi_cnt = 0;
    end else begin
      if (sclk && !p_sclk) begin
        if (sda !== p_sda) unstable++;
        bits = {bits[14:0], sda};
        rises++;
      end else if (sclk && p_sclk && sda !== p_sda) begin
        unstable++;
      end
      if (slatch && (sclk !== 1'b0 || sda !== 1'b0)) bad_latch++;
      if (slatch && !p_slatch) begin
        if (rises != 16) bad_rise++;
        words.push_back(bits);
        lat_cyc.push_back(cyc);
        n_lat++;
        hi_cnt = 0;
      end
      if (slatch) hi_cnt++;
      if (!slatch && p_slatch) begin
        if (hi_cnt != L) bad_latch++;
        rises = 0;
      end
      if (frame_done) fd_cyc.push_back(cyc);
      p_sclk = sclk; p_sda = sda; p_slatch = slatch;
    end
  end

  // Model: the word a digit should shift
  function automatic logic [15:0] exp_word(input int i, input logic [7:0] b,
                                           input logic raw, input logic blk);
    logic [7:0] s;
    s = blk ? 8'hFF : (raw ? b : dec[b]);
    return {8'(1 << i), s};
  endfunction

  function automatic logic [8*N-1:0] pack_bytes();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*(N-1-i) +: 8] = bytes_v[i];
    return v;
  endfunction

  task automatic init_table();
    string k;
    logic [7:0] c;
    logic [7:0] v [18] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80,
                           8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hBF, 8'h7F};
    k = "0123456789ABCDEF-.";
    for (int i = 0; i < 256; i++) dec[i] = 8'hFF;
    for (int i = 0; i < 18; i++) begin
      c = k[i];
      dec[c] = v[i];
      if (i >= 10 && i <= 15) dec[c + 8'h20] = v[i];
    end
  endtask

  task automatic wait_words(input int n, input string tag);
    int b;
    b = 0;
    while (words.size() < n && b < n * PER + 2 * FRAME) begin
      @(negedge clk);
      b++;
    end
    if (words.size() < n) begin
      checks++;
      $display("FAIL %s timeout: got %0d latched words, need %0d", tag, words.size(), n);
    end
  endtask

  task automatic wait_ready(output int rc, input string tag);
    int b;
    b  = 0;
    rc = -1;
    while (b < 2 * FRAME + 100) begin
      @(negedge clk);
      b++;
      if (ready === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      checks++;
      $display("FAIL %s timeout waiting for ready", tag);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input logic raw);
    @(negedge clk);
    data     = pack_bytes();
    raw_mode = raw;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    t0    = cyc;
    rst_n = 1'b1;
    words.delete();
    lat_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sda !== 1'b0) $display("FAIL reset_sda got %b want 0", sda); else passes++;
    checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk); else passes++;
    checks++; if (slatch !== 1'b0) $display("FAIL reset_slatch got %b want 0", slatch); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passes++;
    release_reset();
  endtask

  task automatic test_blank_frame();
    wait_words(N, "blank_frame");
    for (int i = 0; i < N && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_word(i, 8'hFF, 1'b1, 1'b0))
        $display("FAIL blank_word%0d got %h want %h", i, words[i], exp_word(i, 8'hFF, 1'b1, 1'b0));
      else passes++;
    end
    checks++;
    if (lat_cyc.size() == 0 || lat_cyc[0] != t0 + 1 + 32 * D)
      $display("FAIL first_latch_cycle got %0d want %0d", lat_cyc.size() ? lat_cyc[0] - t0 : -1, 1 + 32 * D);
    else passes++;
    wait_until(t0 + 2 * FRAME + 10);
    checks++;
    if (fd_cyc.size() != 2)
      $display("FAIL frame_done_count got %0d want 2", fd_cyc.size());
    else passes++;
    checks++;
    if (fd_cyc.size() < 1 || fd_cyc[0] != t0 + FRAME - 1)
      $display("FAIL frame_done_first got %0d want %0d", fd_cyc.size() ? fd_cyc[0] - t0 : -1, FRAME - 1);
    else passes++;
    checks++;
    if (fd_cyc.size() < 2 || fd_cyc[1] - fd_cyc[0] != FRAME)
      $display("FAIL frame_done_spacing got %0d want %0d", fd_cyc.size() >= 2 ? fd_cyc[1] - fd_cyc[0] : -1, FRAME);
    else passes++;
  endtask

  task automatic test_load_decode();
    int rc;
    logic [7:0] first [8];
    checks++; if (ready !== 1'b1) $display("FAIL load_ready_before got %b want 1", ready); else passes++;
    for (int i = 0; i < N; i++) bytes_v[i] = 8'h30 + 8'(i);
    first = bytes_v;
    do_load(1'b0);
    checks++; if (ready !== 1'b0) $display("FAIL load_ready_drop got %b want 0", ready); else passes++;
    for (int i = 0; i < N; i++) bytes_v[i] = 8'h38 + 8'(i);
    do_load(1'b1);
    checks++; if (ready !== 1'b0) $display("FAIL load_ignored_ready got %b want 0", ready); else passes++;
    wait_ready(rc, "load_decode");
    if (rc < 0) return;
    checks++;
    if ((rc - t0) % FRAME != 1)
      $display("FAIL ready_rise_phase got %0d want 1", (rc - t0) % FRAME);
    else passes++;
    fs = rc - 1;
    words.delete();
    wait_words(2 * N, "load_decode");
    for (int i = 0; i < 2 * N && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_word(i % N, first[i % N], 1'b0, 1'b0))
        $display("FAIL decode_word%0d got %h want %h", i, words[i], exp_word(i % N, first[i % N], 1'b0, 1'b0));
      else passes++;
    end
  endtask

  task automatic test_random();
    int rc;
    logic raw;
    string pool;
    pool = "0123456789AbCdEf-.";
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1, 0) == 0) bytes_v[i] = pool[$urandom_range(17, 0)];
        else bytes_v[i] = 8'($urandom);
      end
      raw = 1'($urandom_range(1, 0));
      do_load(raw);
      wait_ready(rc, "random");
      if (rc < 0) return;
      fs = rc - 1;
      words.delete();
      wait_words(N, "random");
      for (int i = 0; i < N && i < words.size(); i++) begin
        checks++;
        if (words[i] !== exp_word(i, bytes_v[i], raw, 1'b0))
          $display("FAIL random%0d_word%0d got %h want %h", it, i, words[i], exp_word(i, bytes_v[i], raw, 1'b0));
        else passes++;
      end
    end
  endtask

  task automatic test_blank_toggle();
    int rc;
    logic [15:0] w;
    for (int i = 0; i < N; i++) bytes_v[i] = 8'h00;
    do_load(1'b1);
    wait_ready(rc, "blank_toggle");
    if (rc < 0) return;
    fs = rc - 1;
    words.delete();
    wait_until(fs + 3 * PER + 1 + 16 * D);
    blank = 1'b1;
    wait_words(N, "blank_toggle");
    blank = 1'b0;
    for (int i = 0; i < N && i < words.size(); i++) begin
      w = exp_word(i, 8'h00, 1'b1, i >= 4);
      checks++;
      if (words[i] !== w) $display("FAIL blank_toggle_word%0d got %h want %h", i, words[i], w);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int target;
    target = fs + 5 * PER + 1 + 15 * D;
    while (target <= cyc + 2) target += FRAME;
    wait_until(target);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (sclk !== 1'b0) $display("FAIL midreset_sclk got %b want 0", sclk); else passes++;
    checks++; if (sda !== 1'b0) $display("FAIL midreset_sda got %b want 0", sda); else passes++;
    checks++; if (slatch !== 1'b0) $display("FAIL midreset_slatch got %b want 0", slatch); else passes++;
    @(negedge clk);
    checks++; if (slatch !== 1'b0) $display("FAIL midreset_hold_slatch got %b want 0", slatch); else passes++;
    release_reset();
    wait_words(1, "reset_mid_shift");
    checks++;
    if (words.size() < 1 || words[0] !== 16'h01FF)
      $display("FAIL restart_word got %h want 01ff", words.size() ? words[0] : 16'hxxxx);
    else passes++;
    checks++;
    if (lat_cyc.size() < 1 || lat_cyc[0] != t0 + 1 + 32 * D)
      $display("FAIL restart_latch_cycle got %0d want %0d", lat_cyc.size() ? lat_cyc[0] - t0 : -1, 1 + 32 * D);
    else passes++;
  endtask

  task automatic test_serial_timing();
    checks++; if (unstable != 0) $display("FAIL sda_stability got %0d violations want 0", unstable); else passes++;
    checks++; if (bad_rise != 0) $display("FAIL sclk_rises got %0d bad digits want 0", bad_rise); else passes++;
    checks++; if (bad_latch != 0) $display("FAIL latch_shape got %0d bad latches want 0", bad_latch); else passes++;
    checks++; if (n_lat < 9 * N) $display("FAIL latch_count got %0d want >= %0d", n_lat, 9 * N); else passes++;
  endtask

  initial begin
    init_table();
    test_reset();
    test_blank_frame();
    test_load_decode();
    test_random();
    test_blank_toggle();
    test_reset_mid_shift();
    test_serial_timing();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
